axi_burst_master: RTL

AXI_BURST_MASTER -- requirements
Module: axi_burst_master

---
 rtl/axi_burst_master.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/axi_burst_master.sv
// rtl/axi_burst_master.sv - single-outstanding AXI3 burst master with read skid register and timeout abort
module axi_burst_master #(
    parameter int MAX_LEN = 3,
    parameter int TIMEOUT = 1023
) (
    input  logic        ACLK,
    input  logic        ARESETn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [3:0]  req_len,
    input  logic        wd_valid,
    output logic        wd_ready,
    input  logic [31:0] wd_data,
    input  logic [3:0]  wd_strb,
    output logic        rd_valid,
    input  logic        rd_ready,
    output logic [31:0] rd_data,
    output logic        rd_last,
    output logic        done,
    output logic        done_err,
    output logic [31:0] M_AWADDR,
    output logic [3:0]  M_AWLEN,
    output logic [2:0]  M_AWSIZE,
    output logic [1:0]  M_AWBURST,
    output logic        M_AWVALID,
    input  logic        M_AWREADY,
    output logic [31:0] M_WDATA,
    output logic [3:0]  M_WSTRB,
    output logic        M_WVALID,
    input  logic        M_WREADY,
    output logic        M_WLAST,
    input  logic [1:0]  M_BRESP,
    input  logic        M_BVALID,
    output logic        M_BREADY,
    output logic [31:0] M_ARADDR,
    output logic [3:0]  M_ARLEN,
    output logic [2:0]  M_ARSIZE,
    output logic [1:0]  M_ARBURST,
    output logic        M_ARVALID,
    input  logic        M_ARREADY,
    input  logic [31:0] M_RDATA,
    input  logic [1:0]  M_RRESP,
    input  logic        M_RVALID,
    output logic        M_RREADY,
    input  logic        M_RLAST
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_B, S_AR, S_R} state_t;

    state_t         state_q, state_d;
    logic [31:0]    addr_q;
    logic [3:0]     len_q;
    logic [3:0]     len_clamped;
    logic [3:0]     wcnt_q;
    logic [3:0]     rcnt_q;
    logic [31:0]    wdata_q;
    logic [3:0]     wstrb_q;
    logic           wvalid_q;
    logic           wlast_q;
    logic           wd_all_q;
    logic           rd_valid_q;
    logic [31:0]    rd_data_q;
    logic           rd_last_q;
    logic           rd_end_q;
    logic           r_all_q;
    logic           r_err_q;
    logic [TW-1:0]  tmo_cnt_q;

    logic tmo_hit;
    logic req_hs, aw_hs, w_hs, b_hs, ar_hs, r_hs, wd_hs, rd_pop, any_hs;
    logic wd_is_last;
    logic r_is_final, r_end_beat;

    assign len_clamped = (req_len > 4'(MAX_LEN)) ? 4'(MAX_LEN) : req_len;

    // Abort fires in the cycle the idle counter saturates; every valid/ready is masked then.
    assign tmo_hit   = (state_q != S_IDLE) && (tmo_cnt_q == TW'(TIMEOUT));

    assign req_ready = (state_q == S_IDLE) && ARESETn;
    assign M_AWVALID = (state_q == S_AW) && !tmo_hit;
    assign M_ARVALID = (state_q == S_AR) && !tmo_hit;
    assign M_WVALID  = wvalid_q && !tmo_hit;
    assign M_BREADY  = (state_q == S_B) && !tmo_hit;
    assign M_RREADY  = (state_q == S_R) && !r_all_q && (!rd_valid_q || rd_ready) && !tmo_hit;
    assign wd_ready  = (state_q == S_W) && !wd_all_q && (!M_WVALID || M_WREADY) && !tmo_hit;
    assign rd_valid  = rd_valid_q && !tmo_hit;

    assign M_AWADDR  = addr_q;
    assign M_AWLEN   = len_q;
    assign M_AWSIZE  = 3'b010;
    assign M_AWBURST = 2'b01;
    assign M_ARADDR  = addr_q;
    assign M_ARLEN   = len_q;
    assign M_ARSIZE  = 3'b010;
    assign M_ARBURST = 2'b01;
    assign M_WDATA   = wdata_q;
    assign M_WSTRB   = wstrb_q;
    assign M_WLAST   = wlast_q;
    assign rd_data   = rd_data_q;
    assign rd_last   = rd_last_q;

    assign req_hs = req_valid && req_ready;
    assign aw_hs  = M_AWVALID && M_AWREADY;
    assign w_hs   = M_WVALID && M_WREADY;
    assign b_hs   = M_BVALID && M_BREADY;
    assign ar_hs  = M_ARVALID && M_ARREADY;
    assign r_hs   = M_RVALID && M_RREADY;
    assign wd_hs  = wd_valid && wd_ready;
    assign rd_pop = rd_valid && rd_ready;
    assign any_hs = aw_hs || w_hs || b_hs || ar_hs || r_hs;

    // A beat loaded while the register still holds an outgoing beat is the next index.
    assign wd_is_last = ((wcnt_q + {3'b000, wvalid_q}) == len_q);

    // The read burst ends on RLAST or on the expected final beat, whichever comes first.
    assign r_is_final = (rcnt_q == len_q);
    assign r_end_beat = M_RLAST || r_is_final;

    // State register.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic and completion pulse.
    always_comb begin
        state_d  = state_q;
        done     = 1'b0;
        done_err = 1'b0;
        if (tmo_hit) begin
            state_d  = S_IDLE;
            done     = 1'b1;
            done_err = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: if (req_hs) state_d = req_write ? S_AW : S_AR;
                S_AW:   if (aw_hs) state_d = S_W;
                S_W:    if (w_hs && (wcnt_q == len_q)) state_d = S_B;
                S_B: begin
                    if (b_hs) begin
                        done     = 1'b1;
                        done_err = (M_BRESP != 2'b00);
                        state_d  = S_IDLE;
                    end
                end
                S_AR:   if (ar_hs) state_d = S_R;
                S_R: begin
                    if (rd_pop && rd_end_q) begin
                        done     = 1'b1;
                        done_err = r_err_q;
                        state_d  = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Request latch, write beat register, read skid register, beat counters and idle timer.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            addr_q     <= '0;
            len_q      <= '0;
            wcnt_q     <= '0;
            rcnt_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            wvalid_q   <= 1'b0;
            wlast_q    <= 1'b0;
            wd_all_q   <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            rd_last_q  <= 1'b0;
            rd_end_q   <= 1'b0;
            r_all_q    <= 1'b0;
            r_err_q    <= 1'b0;
            tmo_cnt_q  <= '0;
        end else begin
            if ((state_q == S_IDLE) || any_hs || tmo_hit)
                tmo_cnt_q <= '0;
            else if (tmo_cnt_q != TW'(TIMEOUT))
                tmo_cnt_q <= tmo_cnt_q + TW'(1);

            if (req_hs) begin
                addr_q   <= req_addr;
                len_q    <= len_clamped;
                wcnt_q   <= '0;
                rcnt_q   <= '0;
                wd_all_q <= 1'b0;
                r_all_q  <= 1'b0;
                r_err_q  <= 1'b0;
                rd_end_q <= 1'b0;
            end

            if (wd_hs) begin
                wdata_q  <= wd_data;
                wstrb_q  <= wd_strb;
                wvalid_q <= 1'b1;
                wlast_q  <= wd_is_last;
                wd_all_q <= wd_is_last;
            end else if (w_hs) begin
                wvalid_q <= 1'b0;
                wlast_q  <= 1'b0;
            end
            if (w_hs) wcnt_q <= wcnt_q + 4'd1;

            if (r_hs) begin
                rd_valid_q <= 1'b1;
                rd_data_q  <= M_RDATA;
                rd_last_q  <= M_RLAST;
                rd_end_q   <= r_end_beat;
                r_all_q    <= r_end_beat;
                r_err_q    <= r_err_q || (M_RLAST != r_is_final) || (M_RRESP != 2'b00);
                rcnt_q     <= rcnt_q + 4'd1;
            end else if (rd_pop) begin
                rd_valid_q <= 1'b0;
            end

            if (tmo_hit) begin
                wvalid_q   <= 1'b0;
                wlast_q    <= 1'b0;
                rd_valid_q <= 1'b0;
            end
        end
    end

endmodule
